simd_regfile_sb: RTL and testbench
==================================

# simd_regfile_sb

Parametrised dual-issue SIMD register file for the decode/operand-fetch stage. It serves NREAD operands per pipe with synchronous read, write-through bypass, per-operand immediate substitution and writeback forwarding. It also carries a pending-write scoreboard that stalls issue on read-after-write hazards. It sits between decode and the even/odd execute pipes, with pipe 0 as the even pipe and pipe 1 as the odd pipe.

## Interface
Parameters:
- WIDTH, 128: register width in bits; must be a multiple of 32.
- DEPTH, 128: number of registers.
- AW, 7: address width, equal to clog2(DEPTH).
- NPIPES, 2: number of issue pipes.
- NREAD, 3: read operands per pipe.
- CW, 8: width of the control word passed through.

Ports (vectors are packed per pipe, then per operand, with index 0 in the LSBs):
- clk  in  1  clock; all state updates on the rising edge.
- nReset  in  1  asynchronous, active-low reset.
- Flush  in  1  kills the issue stage and clears the scoreboard.
- IssueValid  in  NPIPES  instruction present per pipe.
- RdAddr  in  NPIPES*NREAD*AW  source register addresses.
- RtAddr  in  NPIPES*AW  destination register address.
- Imm  in  NPIPES*32  immediate value.
- ImmSel  in  NPIPES*NREAD  substitutes {WIDTH/32{Imm}} for the operand.
- CtrlIn  in  NPIPES*CW  control word.
- WbValid  in  NPIPES  writeback enable.
- WbAddr  in  NPIPES*AW  writeback address.
- WbData  in  NPIPES*WIDTH  writeback data.
- FwdSel  in  NPIPES*NREAD*2  operand source: 00 = register/immediate, 01 = WbData[0], 10 = WbData[1], 11 = register/immediate.
- OpData  out  NPIPES*NREAD*WIDTH  operand data.
- OutValid  out  NPIPES  issued-instruction valid.
- OutRt  out  NPIPES*AW  registered RtAddr.
- CtrlOut  out  NPIPES*CW  registered CtrlIn.
- Stall  out  1  hazard stall; combinational.

## Operation
- Storage is a DEPTH x WIDTH array and is not reset. Writes: for each p with WbValid[p], mem[WbAddr[p]] <= WbData[p]. On a same-address dual write, pipe 1 wins.
- Read: each operand register is loaded every cycle from mem[RdAddr].
  - If the address matches a valid WbAddr in the same cycle, the register loads that WbData instead (write-through).
  - If both pipes' WbAddr match, pipe 1's data is used.
- Immediate: ImmSel is registered with the read. When it is set, the operand pre-forward value is the replicated Imm, registered in the same cycle as the read.
- Forwarding: OpData is a combinational mux of the registered operand and the current-cycle WbData[0] or WbData[1], selected by the current FwdSel.
- Scoreboard: pending[DEPTH] bits.
  - Set: for each pipe with IssueValid, !Stall and !Flush, set pending[RtAddr].
  - Clear: for each WbValid, clear pending[WbAddr].
  - Same-cycle set and clear of the same address: set wins.
- Stall rule: Stall = 1 when any pipe with IssueValid has an operand with ImmSel=0 whose address is pending and is not being written back by any WbValid this cycle.
- Stall holds the whole issue group. No pending bits are set, and OutValid loads 0 for all pipes. Upstream holds its inputs.
- Flush:
  - Flush takes priority over issue: OutValid, OutRt and CtrlOut load 0, and all pending bits clear.
  - WbValid writes still update mem.
  - Stall is forced to 0 while Flush is high.
- Reset values: OutValid=0, OutRt=0, CtrlOut=0, all pending bits 0, and operand registers 0, so OpData=0 with FwdSel=00.

## Timing
- Read latency is 1 cycle: an address presented at edge N gives its data on OpData after edge N+1.
- OutValid, OutRt and CtrlOut are aligned with OpData.
- FwdSel and WbData act combinationally in the output cycle; there is no added latency.
- A writeback at edge N is visible to a read issued in the same cycle through write-through.
- The scoreboard clear takes effect at the same edge as the write, so a stall due to that register resolves in the writeback cycle itself.
- Stall is combinational from IssueValid, RdAddr, ImmSel, WbValid, WbAddr and pending. There is no path from OpData or FwdSel to Stall.
- Deasserting nReset mid-operation clears state immediately and asynchronously. The first issue is accepted at the first rising edge after release.

## Test plan
- Write/read: WbValid[0]=1, WbAddr=5, WbData=0xA5…A5; two cycles later read r5 on pipe 1 operand 2 -> OpData equals 0xA5…A5 one cycle after the read, with OutValid[1]=1.
- Write-through and dual-write priority: in one cycle, pipe 0 writes r9=0x1…, pipe 1 writes r9=0x2…, and a read of r9 is issued -> operand = 0x2…, and a later read of r9 returns 0x2….
- Immediate and forwarding: ImmSel=1 with Imm=0xDEADBEEF -> operand = 4 x 0xDEADBEEF. In the output cycle, FwdSel=10 with WbData[1]=0x77… -> OpData = 0x77….
- Scoreboard hazard: pipe 0 issues Rt=12; the next cycle pipe 1 reads r12 -> Stall=1 and OutValid=00. Then WbValid[0] on r12 -> Stall=0 in that same cycle, and the operand equals the written data.
- Set-versus-clear race: in one cycle, pipe 0 issues Rt=3 while WbValid clears r3 -> pending[3] remains 1, and a subsequent read of r3 stalls.
- Flush and reset: with pending[20]=1 and OutValid=11, Flush=1 -> the next cycle OutValid=00 and a read of r20 does not stall. Pulsing nReset low asynchronously between edges clears OutValid, OutRt and CtrlOut immediately.

Source files
------------

// File: rtl/simd_regfile_sb_if.sv
// Issue/writeback/operand bundle for simd_regfile_sb.
// Vectors are packed per pipe, then per operand, with index 0 in the LSBs.
interface simd_regfile_sb_if #(
    parameter int unsigned WIDTH  = 128,
    parameter int unsigned AW     = 7,
    parameter int unsigned NPIPES = 2,
    parameter int unsigned NREAD  = 3,
    parameter int unsigned CW     = 8
);
    logic                           Flush;
    logic [NPIPES-1:0]              IssueValid;
    logic [NPIPES*NREAD*AW-1:0]     RdAddr;
    logic [NPIPES*AW-1:0]           RtAddr;
    logic [NPIPES*32-1:0]           Imm;
    logic [NPIPES*NREAD-1:0]        ImmSel;
    logic [NPIPES*CW-1:0]           CtrlIn;
    logic [NPIPES-1:0]              WbValid;
    logic [NPIPES*AW-1:0]           WbAddr;
    logic [NPIPES*WIDTH-1:0]        WbData;
    logic [NPIPES*NREAD*2-1:0]      FwdSel;
    logic [NPIPES*NREAD*WIDTH-1:0]  OpData;
    logic [NPIPES-1:0]              OutValid;
    logic [NPIPES*AW-1:0]           OutRt;
    logic [NPIPES*CW-1:0]           CtrlOut;
    logic                           Stall;

    modport master (
        output Flush, IssueValid, RdAddr, RtAddr, Imm, ImmSel, CtrlIn,
               WbValid, WbAddr, WbData, FwdSel,
        input  OpData, OutValid, OutRt, CtrlOut, Stall
    );

    modport slave (
        input  Flush, IssueValid, RdAddr, RtAddr, Imm, ImmSel, CtrlIn,
               WbValid, WbAddr, WbData, FwdSel,
        output OpData, OutValid, OutRt, CtrlOut, Stall
    );
endinterface

// File: rtl/simd_regfile_sb.sv
// Dual-issue SIMD register file: synchronous operand read with write-through,
// immediate substitution, writeback forwarding and a RAW-hazard scoreboard.
module simd_regfile_sb #(
    parameter int unsigned WIDTH  = 128,
    parameter int unsigned DEPTH  = 128,
    parameter int unsigned AW     = 7,
    parameter int unsigned NPIPES = 2,
    parameter int unsigned NREAD  = 3,
    parameter int unsigned CW     = 8
) (
    input  logic              clk,
    input  logic              nReset,
    simd_regfile_sb_if.slave  bus
);
    localparam int unsigned NOPS = NPIPES * NREAD;
    localparam int unsigned REPL = WIDTH / 32;

    logic [WIDTH-1:0]        mem [DEPTH];
    logic [WIDTH-1:0]        op_d [NOPS];
    logic [WIDTH-1:0]        op_q [NOPS];
    logic [DEPTH-1:0]        pend_d, pend_q;
    logic [NPIPES-1:0]       vld_d, vld_q;
    logic [NPIPES*AW-1:0]    rt_d, rt_q;
    logic [NPIPES*CW-1:0]    ctrl_d, ctrl_q;
    logic                    stall;

    function automatic logic wb_hit(
        input logic [AW-1:0]        a,
        input logic [NPIPES-1:0]    wbv,
        input logic [NPIPES*AW-1:0] wba
    );
        logic h;
        h = 1'b0;
        for (int unsigned w = 0; w < NPIPES; w++) begin
            if (wbv[w] && (wba[w*AW +: AW] == a)) begin
                h = 1'b1;
            end
        end
        return h;
    endfunction

    // Later pipes are written last, so pipe 1 wins a same-address dual write.
    always_ff @(posedge clk) begin
        for (int unsigned p = 0; p < NPIPES; p++) begin
            if (bus.WbValid[p]) begin
                mem[bus.WbAddr[p*AW +: AW]] <= bus.WbData[p*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < NOPS; i++) begin
            op_d[i] = '0;
        end
        for (int unsigned p = 0; p < NPIPES; p++) begin
            for (int unsigned r = 0; r < NREAD; r++) begin
                op_d[p*NREAD+r] = mem[bus.RdAddr[(p*NREAD+r)*AW +: AW]];
                for (int unsigned w = 0; w < NPIPES; w++) begin
                    if (bus.WbValid[w] &&
                        (bus.WbAddr[w*AW +: AW] == bus.RdAddr[(p*NREAD+r)*AW +: AW])) begin
                        op_d[p*NREAD+r] = bus.WbData[w*WIDTH +: WIDTH];
                    end
                end
                if (bus.ImmSel[p*NREAD+r]) begin
                    op_d[p*NREAD+r] = {REPL{bus.Imm[p*32 +: 32]}};
                end
            end
        end
    end

    // A pending source being written back this cycle is already resolved.
    always_comb begin
        stall = 1'b0;
        for (int unsigned p = 0; p < NPIPES; p++) begin
            for (int unsigned r = 0; r < NREAD; r++) begin
                if (bus.IssueValid[p] && !bus.ImmSel[p*NREAD+r] &&
                    pend_q[bus.RdAddr[(p*NREAD+r)*AW +: AW]] &&
                    !wb_hit(bus.RdAddr[(p*NREAD+r)*AW +: AW], bus.WbValid, bus.WbAddr)) begin
                    stall = 1'b1;
                end
            end
        end
        if (bus.Flush) begin
            stall = 1'b0;
        end
    end

    always_comb begin
        pend_d = pend_q;
        if (bus.Flush) begin
            pend_d = '0;
        end else begin
            for (int unsigned w = 0; w < NPIPES; w++) begin
                if (bus.WbValid[w]) begin
                    pend_d[bus.WbAddr[w*AW +: AW]] = 1'b0;
                end
            end
            // Sets applied after clears so a same-cycle issue keeps the bit.
            if (!stall) begin
                for (int unsigned p = 0; p < NPIPES; p++) begin
                    if (bus.IssueValid[p]) begin
                        pend_d[bus.RtAddr[p*AW +: AW]] = 1'b1;
                    end
                end
            end
        end
    end

    always_comb begin
        vld_d  = bus.IssueValid;
        rt_d   = bus.RtAddr;
        ctrl_d = bus.CtrlIn;
        if (bus.Flush) begin
            vld_d  = '0;
            rt_d   = '0;
            ctrl_d = '0;
        end else if (stall) begin
            vld_d  = '0;
        end
    end

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            pend_q <= '0;
            vld_q  <= '0;
            rt_q   <= '0;
            ctrl_q <= '0;
            for (int unsigned i = 0; i < NOPS; i++) begin
                op_q[i] <= '0;
            end
        end else begin
            pend_q <= pend_d;
            vld_q  <= vld_d;
            rt_q   <= rt_d;
            ctrl_q <= ctrl_d;
            for (int unsigned i = 0; i < NOPS; i++) begin
                op_q[i] <= op_d[i];
            end
        end
    end

    always_comb begin
        bus.OpData = '0;
        for (int unsigned i = 0; i < NOPS; i++) begin
            unique case (bus.FwdSel[i*2 +: 2])
                2'b01:   bus.OpData[i*WIDTH +: WIDTH] = bus.WbData[0 +: WIDTH];
                2'b10:   bus.OpData[i*WIDTH +: WIDTH] = bus.WbData[WIDTH +: WIDTH];
                default: bus.OpData[i*WIDTH +: WIDTH] = op_q[i];
            endcase
        end
    end

    assign bus.OutValid = vld_q;
    assign bus.OutRt    = rt_q;
    assign bus.CtrlOut  = ctrl_q;
    assign bus.Stall    = stall;
endmodule

// File: tb/tb_simd_regfile_sb.sv
// Directed bench for simd_regfile_sb: hand-computed expectations checked with
// immediate assertions; inputs driven 1 time unit after the rising edge.
module tb_simd_regfile_sb;
    localparam int unsigned WIDTH  = 128;
    localparam int unsigned DEPTH  = 128;
    localparam int unsigned AW     = 7;
    localparam int unsigned NPIPES = 2;
    localparam int unsigned NREAD  = 3;
    localparam int unsigned CW     = 8;

    logic clk = 1'b0;
    logic nReset;
    always #5 clk = ~clk;

    simd_regfile_sb_if #(.WIDTH(WIDTH), .AW(AW), .NPIPES(NPIPES), .NREAD(NREAD), .CW(CW)) bus ();

    simd_regfile_sb #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW), .NPIPES(NPIPES), .NREAD(NREAD), .CW(CW)
    ) dut (
        .clk(clk),
        .nReset(nReset),
        .bus(bus)
    );

    int pass_cnt  = 0;
    int fail_cnt  = 0;
    int total_cnt = 0;

    task automatic chk(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        bus.Flush      = 1'b0;
        bus.IssueValid = '0;
        bus.RdAddr     = '0;
        bus.RtAddr     = '0;
        bus.Imm        = '0;
        bus.ImmSel     = '0;
        bus.CtrlIn     = '0;
        bus.WbValid    = '0;
        bus.WbAddr     = '0;
        bus.WbData     = '0;
        bus.FwdSel     = '0;
    endtask

    task automatic set_rd(input int p, input int r, input logic [AW-1:0] a);
        bus.RdAddr[(p*NREAD+r)*AW +: AW] = a;
    endtask

    task automatic set_issue(input int p, input logic [AW-1:0] rt, input logic [CW-1:0] c);
        bus.IssueValid[p]        = 1'b1;
        bus.RtAddr[p*AW +: AW]   = rt;
        bus.CtrlIn[p*CW +: CW]   = c;
    endtask

    task automatic set_wb(input int p, input logic [AW-1:0] a, input logic [WIDTH-1:0] d);
        bus.WbValid[p]                = 1'b1;
        bus.WbAddr[p*AW +: AW]        = a;
        bus.WbData[p*WIDTH +: WIDTH]  = d;
    endtask

    function automatic logic [WIDTH-1:0] op(input int p, input int r);
        return bus.OpData[(p*NREAD+r)*WIDTH +: WIDTH];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        idle();
        nReset = 1'b0;
        #2;
        chk("rst_outvalid", WIDTH'(bus.OutValid), '0);
        chk("rst_outrt",    WIDTH'(bus.OutRt),    '0);
        chk("rst_ctrlout",  WIDTH'(bus.CtrlOut),  '0);
        chk("rst_opdata",   WIDTH'(|bus.OpData),  '0);
        chk("rst_stall",    WIDTH'(bus.Stall),    '0);
        #1 nReset = 1'b1;

        // Write r5, read it two cycles later on pipe 1 operand 2
        set_wb(0, 7'd5, {4{32'hA5A5A5A5}});
        tick(); idle();
        tick();
        set_issue(1, 7'd40, 8'h3C);
        set_rd(1, 2, 7'd5);
        #1 chk("rd_stall", WIDTH'(bus.Stall), '0);
        tick(); idle();
        chk("rd_data",     op(1, 2), {4{32'hA5A5A5A5}});
        chk("rd_outvalid", WIDTH'(bus.OutValid), WIDTH'(2'b10));
        chk("rd_outrt",    WIDTH'(bus.OutRt[AW +: AW]), WIDTH'(7'd40));
        chk("rd_ctrlout",  WIDTH'(bus.CtrlOut[CW +: CW]), WIDTH'(8'h3C));

        // Same-cycle dual write to r9 with a read of r9: pipe 1 wins
        set_wb(0, 7'd9, {4{32'h11111111}});
        set_wb(1, 7'd9, {4{32'h22222222}});
        set_issue(0, 7'd41, 8'h01);
        set_rd(0, 0, 7'd9);
        tick(); idle();
        chk("wt_data",     op(0, 0), {4{32'h22222222}});
        chk("wt_outvalid", WIDTH'(bus.OutValid), WIDTH'(2'b01));
        set_issue(0, 7'd42, 8'h02);
        set_rd(0, 1, 7'd9);
        tick(); idle();
        chk("dual_wr_mem", op(0, 1), {4{32'h22222222}});

        // Immediate substitution, then forwarding in the output cycle
        set_issue(0, 7'd43, 8'h03);
        bus.ImmSel[0]  = 1'b1;
        bus.Imm[31:0]  = 32'hDEADBEEF;
        tick(); idle();
        chk("imm_data", op(0, 0), {4{32'hDEADBEEF}});
        bus.FwdSel[1:0] = 2'b10;
        bus.WbData[WIDTH +: WIDTH] = {4{32'h77777777}};
        #1 chk("fwd_wb1", op(0, 0), {4{32'h77777777}});
        bus.FwdSel[1:0] = 2'b01;
        bus.WbData[0 +: WIDTH] = {4{32'h55555555}};
        #1 chk("fwd_wb0", op(0, 0), {4{32'h55555555}});
        bus.FwdSel[1:0] = 2'b11;
        #1 chk("fwd_11_reg", op(0, 0), {4{32'hDEADBEEF}});
        idle();

        // RAW hazard on r12, resolved by a writeback in the stall cycle
        set_issue(0, 7'd12, 8'h04);
        tick(); idle();
        set_issue(1, 7'd44, 8'h05);
        set_rd(1, 0, 7'd12);
        #1 chk("haz_stall", WIDTH'(bus.Stall), WIDTH'(1'b1));
        tick();
        chk("haz_outvalid", WIDTH'(bus.OutValid), WIDTH'(2'b00));
        chk("haz_stall_hold", WIDTH'(bus.Stall), WIDTH'(1'b1));
        set_wb(0, 7'd12, {4{32'hC3C3C3C3}});
        #1 chk("haz_wb_release", WIDTH'(bus.Stall), '0);
        tick(); idle();
        chk("haz_issue_valid", WIDTH'(bus.OutValid), WIDTH'(2'b10));
        chk("haz_data", op(1, 0), {4{32'hC3C3C3C3}});

        // Same-cycle set and clear of r3: set wins
        set_issue(0, 7'd3, 8'h06);
        set_wb(0, 7'd3, {4{32'h33333333}});
        tick(); idle();
        set_issue(1, 7'd45, 8'h07);
        set_rd(1, 1, 7'd3);
        #1 chk("race_stall", WIDTH'(bus.Stall), WIDTH'(1'b1));
        idle();

        // Flush clears outputs and the scoreboard; Stall masked under Flush
        set_issue(0, 7'd20, 8'h08);
        set_issue(1, 7'd21, 8'h09);
        tick(); idle();
        chk("fl_pre_valid", WIDTH'(bus.OutValid), WIDTH'(2'b11));
        set_issue(0, 7'd46, 8'h0A);
        set_rd(0, 0, 7'd20);
        #1 chk("fl_pre_stall", WIDTH'(bus.Stall), WIDTH'(1'b1));
        bus.Flush = 1'b1;
        #1 chk("fl_stall_mask", WIDTH'(bus.Stall), '0);
        tick(); idle();
        chk("fl_outvalid", WIDTH'(bus.OutValid), '0);
        chk("fl_outrt",    WIDTH'(bus.OutRt), '0);
        chk("fl_ctrlout",  WIDTH'(bus.CtrlOut), '0);
        set_issue(0, 7'd47, 8'h0B);
        set_rd(0, 0, 7'd20);
        #1 chk("fl_no_stall", WIDTH'(bus.Stall), '0);
        idle();

        // Asynchronous reset pulse between edges
        set_issue(0, 7'd50, 8'hA1);
        set_issue(1, 7'd51, 8'hB2);
        tick(); idle();
        chk("ar_pre_valid", WIDTH'(bus.OutValid), WIDTH'(2'b11));
        chk("ar_pre_rt",    WIDTH'(bus.OutRt), WIDTH'({7'd51, 7'd50}));
        #2 nReset = 1'b0;
        #1;
        chk("ar_outvalid", WIDTH'(bus.OutValid), '0);
        chk("ar_outrt",    WIDTH'(bus.OutRt), '0);
        chk("ar_ctrlout",  WIDTH'(bus.CtrlOut), '0);
        chk("ar_opdata",   WIDTH'(|bus.OpData), '0);
        nReset = 1'b1;
        set_issue(0, 7'd52, 8'h0C);
        set_rd(0, 0, 7'd5);
        tick(); idle();
        chk("ar_first_issue", WIDTH'(bus.OutValid), WIDTH'(2'b01));
        chk("ar_mem_kept",    op(0, 0), {4{32'hA5A5A5A5}});

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
